// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage: owns the fetch PC, issues word requests to instruction memory
// and buffers returned instructions in a small FIFO presented to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds fetch_fault/fetch_fault_pc;
// a misaligned redirect raises a sticky fault instead of refetching).
module fetch_prefetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_fault,
    output logic [31:0] fetch_fault_pc,
`endif
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcplus4
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [31:0]        fetch_pc;
    logic [31:0]        inflight_pc;
    logic               inflight;
    logic               inflight_epoch;
    logic               epoch;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic               pop;
    logic               push;
    logic               issue;
    logic               redir_ok;
    logic [31:0]        redir_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned targets are rejected; aligned ones are taken as-is.
    always_comb begin
        redir_ok     = (redirect_pc[1:0] == 2'b00);
        redir_target = redirect_pc;
    end
`else
    logic [1:0] unused_redirect_lo;
    assign unused_redirect_lo = redirect_pc[1:0];

    // Low target bits are ignored; every redirect is taken word-aligned.
    always_comb begin
        redir_ok     = 1'b1;
        redir_target = {redirect_pc[31:2], 2'b00};
    end
`endif

    // Handshake decode, issue decision and decoder-facing head view.
    always_comb begin
        id_valid = (count != '0);
        pop      = id_valid & id_ready;
        push     = imem_rvalid & inflight & (inflight_epoch == epoch);
        occ      = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        issue    = ~rst & ~redirect_valid & (occ < OCC_W'(DEPTH));
`ifdef FETCH_MISALIGN_TRAP_EN
        issue    = issue & ~fetch_fault;
`endif
        imem_req   = issue;
        imem_addr  = fetch_pc;
        head       = mem[rd_ptr];
        id_instr   = id_valid ? head.instr : NOP;
        id_pc      = id_valid ? head.pc : 32'h0000_0000;
        id_pcplus4 = id_pc + 32'd4;
    end

    // Fetch PC, in-flight tracking, epoch and FIFO bookkeeping; redirect dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= 32'h0000_0000;
            epoch          <= 1'b0;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_epoch <= epoch;
                inflight_pc    <= fetch_pc;
                fetch_pc       <= fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                epoch  <= ~epoch;
                if (redir_ok) begin
                    fetch_pc <= redir_target;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage: capture {instr, pc} of a current-epoch response.
    always_ff @(posedge clk) begin
        if (~rst & ~redirect_valid & push) begin
            mem[wr_ptr] <= '{instr: imem_rdata, pc: inflight_pc};
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misaligned-redirect fault, cleared by a legal redirect or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault    <= 1'b0;
            fetch_fault_pc <= 32'h0000_0000;
        end else if (redirect_valid) begin
            if (!redir_ok) begin
                fetch_fault    <= 1'b1;
                fetch_fault_pc <= redirect_pc;
            end else begin
                fetch_fault <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: queue-based fetch model, 1-cycle imem
// responder with stray responses, directed scenarios and a random soak.
module tb_fetch_prefetch_buffer;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] XK       = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
    logic [31:0] fetch_fault_pc;
`endif

    fetch_prefetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault    (fetch_fault),
        .fetch_fault_pc (fetch_fault_pc),
`endif
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Behavioural model state
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_inf_pc;
    bit          m_inf;
`ifdef FETCH_MISALIGN_TRAP_EN
    bit          m_fault;
    logic [31:0] m_fault_pc;
`endif

    int          checks;
    int          errors;
    bit          prev_req;
    logic [31:0] prev_addr;
    logic [31:0] cur_req, cur_addr, cur_valid, cur_pc, cur_instr, cur_p4;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = RESET_PC;
        m_inf      = 1'b0;
        m_inf_pc   = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
`endif
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy, input bit cmp);
        bit          e_valid;
        bit          e_pop;
        bit          e_req;
        int          occ;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        imem_rvalid    = prev_req;
        imem_rdata     = prev_addr ^ XK;
        if (!prev_req && $urandom_range(0, 3) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        #1;
        e_valid = (mq.size() > 0);
        e_pop   = e_valid && rdy;
        occ     = mq.size() + int'(m_inf) - int'(e_pop);
        e_req   = !r && !rv && (occ < int'(DEPTH));
`ifdef FETCH_MISALIGN_TRAP_EN
        e_req   = e_req && !m_fault;
`endif
        e_pc    = e_valid ? mq[0].pc : 32'h0;
        e_instr = e_valid ? mq[0].instr : NOP;
        if (cmp) begin
            chk("imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) begin
                chk("imem_addr", imem_addr, m_fetch_pc);
                chk("imem_addr_lo", 32'(imem_addr[1:0]), 32'h0);
            end
            chk("id_valid", 32'(id_valid), 32'(e_valid));
            chk("id_instr", id_instr, e_instr);
            chk("id_pc", id_pc, e_pc);
            chk("id_pcplus4", id_pcplus4, e_pc + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            chk("fetch_fault_pc", fetch_fault_pc, m_fault_pc);
`endif
        end
        cur_req   = 32'(imem_req);
        cur_addr  = imem_addr;
        cur_valid = 32'(id_valid);
        cur_pc    = id_pc;
        cur_instr = id_instr;
        cur_p4    = id_pcplus4;
        prev_req  = imem_req;
        prev_addr = imem_addr;
        if (r) begin
            model_reset();
        end else if (rv) begin
            mq.delete();
            m_inf = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                m_fault    = 1'b1;
                m_fault_pc = rpc;
            end else begin
                m_fault    = 1'b0;
                m_fetch_pc = rpc;
            end
`else
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
`endif
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (imem_rvalid && m_inf) begin
                if (mq.size() >= DEPTH) begin
                    errors++;
                    $display("FAIL overflow push into full fifo t=%0t", $time);
                end
                mq.push_back('{instr: imem_rdata, pc: m_inf_pc});
            end
            if (e_req) begin
                m_inf_pc   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            m_inf = e_req;
        end
    endtask

    bit          r_rst, r_rv, r_rdy;
    logic [31:0] r_pc;

    initial begin
        checks = 0;
        errors = 0;
        prev_req = 1'b0;
        prev_addr = 32'h0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        model_reset();

        // Reset state
        repeat (2) step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 1);
        chk("rst_valid", cur_valid, 32'h0);
        chk("rst_instr", cur_instr, NOP);
        chk("rst_pc", cur_pc, 32'h0);
        chk("rst_req", cur_req, 32'h0);

        // First fetch latency, then stall right after the first valid
        step(0, 0, 32'h0, 1, 1);
        chk("c0_req", cur_req, 32'h1);
        chk("c0_addr", cur_addr, 32'h0);
        step(0, 0, 32'h0, 1, 1);
        chk("c1_valid", cur_valid, 32'h0);
        step(0, 0, 32'h0, 0, 1);
        chk("c2_valid", cur_valid, 32'h1);
        chk("c2_pc", cur_pc, 32'h0);
        chk("c2_instr", cur_instr, 32'hA5A5_0000);
        chk("c2_p4", cur_p4, 32'h4);
        repeat (5) step(0, 0, 32'h0, 0, 1);
        chk("stall_req", cur_req, 32'h0);
        chk("stall_pc", cur_pc, 32'h0);
        chk("stall_valid", cur_valid, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 1, 1);
            chk("release_pc", cur_pc, 32'(4 * i));
            chk("release_valid", cur_valid, 32'h1);
        end
        repeat (4) step(0, 0, 32'h0, 1, 1);

        // Redirect after filling, with a response in flight
        repeat (3) step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 1);
        step(0, 1, 32'h0000_0100, 0, 1);
        chk("redir_req", cur_req, 32'h0);
        step(0, 0, 32'h0, 1, 1);
        chk("redir_t1_req", cur_req, 32'h1);
        chk("redir_t1_addr", cur_addr, 32'h0000_0100);
        chk("redir_t1_valid", cur_valid, 32'h0);
        step(0, 0, 32'h0, 1, 1);
        chk("redir_t2_valid", cur_valid, 32'h0);
        step(0, 0, 32'h0, 1, 1);
        chk("redir_t3_valid", cur_valid, 32'h1);
        chk("redir_t3_pc", cur_pc, 32'h0000_0100);
        chk("redir_t3_instr", cur_instr, 32'hA5A5_0100);

        // Back-to-back redirects: last one wins
        step(0, 1, 32'h0000_0200, 1, 1);
        step(0, 1, 32'h0000_0300, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("b2b_addr", cur_addr, 32'h0000_0300);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("b2b_pc", cur_pc, 32'h0000_0300);

        // PC wrap-around
        step(0, 1, 32'hFFFF_FFF8, 1, 1);
        repeat (3) step(0, 0, 32'h0, 1, 1);
        chk("wrap_pc0", cur_pc, 32'hFFFF_FFF8);
        step(0, 0, 32'h0, 1, 1);
        chk("wrap_pc1", cur_pc, 32'hFFFF_FFFC);
        chk("wrap_p4", cur_p4, 32'h0);
        step(0, 0, 32'h0, 1, 1);
        chk("wrap_pc2", cur_pc, 32'h0);

        // Misaligned redirect target
`ifdef FETCH_MISALIGN_TRAP_EN
        step(0, 1, 32'h0000_0102, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("fault_set", 32'(fetch_fault), 32'h1);
        chk("fault_pc", fetch_fault_pc, 32'h0000_0102);
        chk("fault_noreq", cur_req, 32'h0);
        repeat (3) step(0, 0, 32'h0, 1, 1);
        chk("fault_hold_req", cur_req, 32'h0);
        step(0, 1, 32'h0000_0040, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("fault_clr", 32'(fetch_fault), 32'h0);
        chk("fault_clr_addr", cur_addr, 32'h0000_0040);
`else
        step(0, 1, 32'h0000_0102, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("mask_addr", cur_addr, 32'h0000_0100);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("mask_pc", cur_pc, 32'h0000_0100);
`endif

        // Reset in the middle of a stream
        repeat (3) step(0, 0, 32'h0, 1, 1);
        step(1, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("midrst_valid", cur_valid, 32'h0);
        chk("midrst_addr", cur_addr, RESET_PC);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk("midrst_pc", cur_pc, RESET_PC);

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_rv  = ($urandom_range(0, 99) < 6);
            r_pc  = $urandom;
            if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
            r_rdy = ($urandom_range(0, 99) < 75);
            step(r_rst, r_rv, r_pc, r_rdy, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
